bcd_counter_n: RTL and testbench

- Parametrised multi-digit BCD up/down counter; successor to the fixed two-digit tens/units counter.
- Adds the following features:
  - configurable digit count
  - programmable wrap limit
  - count enable
  - direction control
  - synchronous parallel load with BCD validation
  - registered wrap pulse for cascading
- Used as a time/event counter feeding display drivers and as a cascadable stage for wider decimal counters.

---
 rtl/bcd_pkg.sv | 25 ++
 rtl/bcd_digit.sv | 34 +++
 rtl/bcd_counter_n.sv | 93 +++++++++
 tb/tb_bcd_counter_n.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD definitions: digit limit, direction encoding and a nibble-validity helper.
package bcd_pkg;

    localparam int unsigned BCD_MAX_DIGITS = 8;
    localparam int unsigned BCD_VEC_W      = 4 * BCD_MAX_DIGITS;

    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

    localparam logic UP   = 1'b1;
    localparam logic DOWN = 1'b0;

    // True when each of the low 'digits' nibbles of vec is in 0..9.
    function automatic logic is_valid_bcd(input logic [BCD_VEC_W-1:0] vec,
                                          input int unsigned          digits);
        logic ok;
        ok = 1'b1;
        for (int unsigned i = 0; i < BCD_MAX_DIGITS; i++) begin
            if (i < digits && vec[4*i +: 4] > BCD_MAX_DIGIT) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the counter: applies an incoming carry/borrow and reports the outgoing one.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       step_in,
    input  logic       up_dn,
    output logic [3:0] digit_nxt_c,
    output logic       step_out_c
);

    always_comb begin
        digit_nxt_c = digit;
        step_out_c  = 1'b0;
        if (step_in) begin
            if (up_dn == UP) begin
                if (digit >= BCD_MAX_DIGIT) begin
                    digit_nxt_c = 4'd0;
                    step_out_c  = 1'b1;
                end else begin
                    digit_nxt_c = digit + 4'd1;
                end
            end else begin
                if (digit == 4'd0) begin
                    digit_nxt_c = BCD_MAX_DIGIT;
                    step_out_c  = 1'b1;
                end else begin
                    digit_nxt_c = digit - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_counter_n.sv
// Multi-digit BCD up/down counter with programmable wrap limit, validated load and
// registered wrap / load-error pulses for cascading.
module bcd_counter_n
    import bcd_pkg::*;
#(
    parameter  int unsigned          DIGITS  = 2,
    localparam int unsigned          W       = 4 * DIGITS,
    parameter  logic [W-1:0]         MAX_BCD = W'(8'h99)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         up_dn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         load_err
);

    logic [W-1:0]    count_q, count_d;
    logic            wrap_q, wrap_d;
    logic            load_err_q, load_err_d;

    logic [DIGITS:0] step_c;
    logic [W-1:0]    stepped_c;
    logic            at_zero_c;
    logic            load_ok_c;

    assign step_c[0] = 1'b1;

    // Ripple chain: each decade consumes the carry/borrow from the one below it.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .digit       (count_q[4*g +: 4]),
            .step_in     (step_c[g]),
            .up_dn       (up_dn),
            .digit_nxt_c (stepped_c[4*g +: 4]),
            .step_out_c  (step_c[g+1])
        );
    end

    // A borrow out of the top decade happens exactly when every digit is zero.
    assign at_zero_c = (up_dn == DOWN) && step_c[DIGITS];

    assign load_ok_c = is_valid_bcd(BCD_VEC_W'(load_val), DIGITS) && (load_val <= MAX_BCD);

    always_comb begin
        count_d    = count_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (load) begin
            if (load_ok_c) begin
                count_d = load_val;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (en) begin
            if (up_dn == UP) begin
                if (count_q == MAX_BCD) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = stepped_c;
                end
            end else begin
                if (at_zero_c) begin
                    count_d = MAX_BCD;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = stepped_c;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign count    = count_q;
    assign wrap     = wrap_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Scoreboard bench for bcd_counter_n: three configurations driven in lockstep against a decimal model.
module tb_bcd_counter_n;

    typedef struct packed {
        logic [15:0] cnt;
        logic        wrap;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, en, up_dn, load;
    logic [15:0] load_val;

    logic [7:0]  c0, c1;
    logic [15:0] c2;
    logic        w0, w1, w2, e0, e1, e2;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    int m_cnt [3];
    int m_max [3] = '{99, 59, 9999};
    int m_dig [3] = '{2, 2, 4};

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    bcd_counter_n #(.DIGITS(2), .MAX_BCD(8'h99)) u_99 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val[7:0]), .count(c0), .wrap(w0), .load_err(e0));

    bcd_counter_n #(.DIGITS(2), .MAX_BCD(8'h59)) u_59 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val[7:0]), .count(c1), .wrap(w1), .load_err(e1));

    bcd_counter_n #(.DIGITS(4), .MAX_BCD(16'h9999)) u_4 (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .count(c2), .wrap(w2), .load_err(e2));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int bcd2int(input logic [15:0] v, input int nd);
        int r;
        logic [3:0] d;
        r = 0;
        for (int i = nd - 1; i >= 0; i--) begin
            d = v[4*i +: 4];
            if (d > 4'd9) return -1;
            r = r * 10 + int'(d);
        end
        return r;
    endfunction

    function automatic logic [15:0] int2bcd(input int n, input int nd);
        logic [15:0] r;
        int x;
        r = '0;
        x = n;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Decimal reference: advances model k by one edge and returns the expected outputs.
    function automatic exp_t model(input int k);
        exp_t e;
        int v;
        e.wrap = 1'b0;
        e.err  = 1'b0;
        if (rst) begin
            m_cnt[k] = 0;
        end else if (load) begin
            v = bcd2int(load_val, m_dig[k]);
            if (v < 0 || v > m_max[k]) e.err = 1'b1;
            else m_cnt[k] = v;
        end else if (en) begin
            if (up_dn) begin
                if (m_cnt[k] == m_max[k]) begin m_cnt[k] = 0; e.wrap = 1'b1; end
                else m_cnt[k] = m_cnt[k] + 1;
            end else begin
                if (m_cnt[k] == 0) begin m_cnt[k] = m_max[k]; e.wrap = 1'b1; end
                else m_cnt[k] = m_cnt[k] - 1;
            end
        end
        e.cnt = int2bcd(m_cnt[k], m_dig[k]);
        return e;
    endfunction

    task automatic cmp(input string nm, input logic [15:0] c, input logic w, input logic er,
                       input exp_t e);
        check({nm, "_cnt"},  32'(c),  32'(e.cnt));
        check({nm, "_wrap"}, 32'(w),  32'(e.wrap));
        check({nm, "_err"},  32'(er), 32'(e.err));
    endtask

    task automatic cyc();
        exp_t e;
        q0.push_back(model(0));
        q1.push_back(model(1));
        q2.push_back(model(2));
        @(posedge clk);
        #1;
        e = q0.pop_front(); cmp("u99", 16'(c0), w0, e0, e);
        e = q1.pop_front(); cmp("u59", 16'(c1), w1, e1, e);
        e = q2.pop_front(); cmp("u4",  c2,      w2, e2, e);
    endtask

    task automatic drive(input logic r, input logic l, input logic [15:0] lv,
                         input logic e, input logic u);
        rst = r; load = l; load_val = lv; en = e; up_dn = u;
    endtask

    logic [7:0]  exp_seq [4];
    logic        exp_wr  [4];
    logic [15:0] lv_r;

    initial begin
        drive(1'b1, 1'b1, 16'h0042, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            cyc();
            check("rst_cnt", 32'(c0), 32'h0);
            check("rst_wrap", 32'(w0), 32'h0);
            check("rst_err", 32'(e0), 32'h0);
        end

        // up-count through the 99 -> 00 boundary
        drive(1'b0, 1'b1, 16'h0097, 1'b0, 1'b1);
        cyc();
        check("ld97_u59_err", 32'(e1), 32'h1);
        exp_seq = '{8'h98, 8'h99, 8'h00, 8'h01};
        exp_wr  = '{1'b0, 1'b0, 1'b1, 1'b0};
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("up_seq_cnt", 32'(c0), 32'(exp_seq[i]));
            check("up_seq_wrap", 32'(w0), 32'(exp_wr[i]));
        end

        // down-count wrap in mod-60
        drive(1'b0, 1'b1, 16'h0001, 1'b0, 1'b0);
        cyc();
        exp_seq = '{8'h00, 8'h59, 8'h58, 8'h58};
        exp_wr  = '{1'b0, 1'b1, 1'b0, 1'b0};
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("dn_seq_cnt", 32'(c1), 32'(exp_seq[i]));
            check("dn_seq_wrap", 32'(w1), 32'(exp_wr[i]));
        end
        drive(1'b0, 1'b1, 16'h0050, 1'b0, 1'b0);
        cyc();
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        cyc();
        check("borrow_50_49", 32'(c1), 32'h49);

        // rejected loads, with en high
        drive(1'b0, 1'b1, 16'h003A, 1'b1, 1'b1);
        cyc();
        check("rej3a_cnt", 32'(c0), 32'h49);
        check("rej3a_err", 32'(e0), 32'h1);
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        cyc();
        check("rej3a_err_once", 32'(e0), 32'h0);
        drive(1'b0, 1'b1, 16'h0060, 1'b1, 1'b1);
        cyc();
        check("rej60_cnt", 32'(c1), 32'h49);
        check("rej60_err", 32'(e1), 32'h1);
        check("acc60_u99", 32'(c0), 32'h60);

        // load priority over en, hold, direction toggle
        drive(1'b0, 1'b1, 16'h0025, 1'b1, 1'b1);
        cyc();
        check("ld25_no_step", 32'(c0), 32'h25);
        drive(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            check("hold25", 32'(c0), 32'h25);
        end
        exp_seq = '{8'h26, 8'h25, 8'h26, 8'h26};
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 16'h0000, 1'b1, (i % 2 == 0) ? 1'b1 : 1'b0);
            cyc();
            check("toggle_dir", 32'(c0), 32'(exp_seq[i]));
        end

        // four-digit ripple
        drive(1'b0, 1'b1, 16'h0999, 1'b0, 1'b1);
        cyc();
        drive(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        cyc();
        check("ripple_1000", 32'(c2), 32'h1000);

        // random soak against the model
        for (int i = 0; i < 20000; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                for (int d = 0; d < 4; d++) lv_r[4*d +: 4] = 4'($urandom_range(0, 9));
            end else begin
                lv_r = 16'($urandom);
            end
            drive(($urandom_range(0, 499) == 0), ($urandom_range(0, 15) == 0), lv_r,
                  ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
            cyc();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
